// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit PRBS generator/checker pair
// (recurrence x^4+x^3+1, period 15).
package lfsr_pkg;

   localparam int          LFSR_W    = 4;
   localparam int          TAP_A     = 4;
   localparam int          TAP_B     = 3;
   localparam logic [3:0]  LFSR_SEED = 4'b1111;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lfsr_chk_state_e;

   // Next stream bit predicted from the history; bit k-1 holds hist[k].
   function automatic logic lfsr_pred(input logic [LFSR_W-1:0] hist);
      return hist[TAP_A-1] ^ hist[TAP_B-1];
   endfunction

endpackage

// File: rtl/lfsr_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module lfsr_chk_sat_cnt
   import lfsr_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // Count register: clear wins over hold, saturate at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= i_inc ? W'(1) : '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 4-bit PRBS stream: fills a history register,
// verifies LOCK_CNT predicted bits, then flywheels on its own prediction and
// flags mismatches. Drops back to SEARCH after LOSS_CNT consecutive misses.
// Optional feature macro: LFSR_CHK_ERR_CNT_EN (builds the error counter and
// clr_err handling; otherwise err_cnt is tied to zero).
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);

   lfsr_chk_state_e   r_state, w_state_nxt;
   logic [LFSR_W-1:0] r_hist,  w_hist_nxt;
   logic [1:0]        r_fill,  w_fill_nxt;
   logic [MW-1:0]     r_match, w_match_nxt;
   logic [LW-1:0]     r_miss,  w_miss_nxt;
   logic              r_err_pulse;
   logic              w_err;
   logic              w_pred;

   assign w_pred = lfsr_pred(r_hist);

   // State and counter registers; everything returns to its idle value on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= SEARCH;
         r_hist      <= '0;
         r_fill      <= '0;
         r_match     <= '0;
         r_miss      <= '0;
         r_err_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hist      <= w_hist_nxt;
         r_fill      <= w_fill_nxt;
         r_match     <= w_match_nxt;
         r_miss      <= w_miss_nxt;
         r_err_pulse <= w_err;
      end
   end

   // Next-state logic; nothing moves on beats without in_valid.
   always_comb begin
      w_state_nxt = r_state;
      w_hist_nxt  = r_hist;
      w_fill_nxt  = r_fill;
      w_match_nxt = r_match;
      w_miss_nxt  = r_miss;
      w_err       = 1'b0;
      if (in_valid) begin
         case (r_state)
            SEARCH: begin
               w_hist_nxt = {r_hist[LFSR_W-2:0], in_bit};
               if (r_fill == 2'd3) begin
                  w_state_nxt = VERIFY;
                  w_fill_nxt  = '0;
                  w_match_nxt = '0;
               end else begin
                  w_fill_nxt = r_fill + 1'b1;
               end
            end
            VERIFY: begin
               w_hist_nxt = {r_hist[LFSR_W-2:0], in_bit};
               // An all-zero history predicts zeros forever; never trust it.
               if (r_hist == '0) begin
                  w_match_nxt = '0;
               end else if (in_bit == w_pred) begin
                  if (r_match == MW'(LOCK_CNT - 1)) begin
                     w_state_nxt = LOCKED;
                     w_match_nxt = '0;
                     w_miss_nxt  = '0;
                  end else begin
                     w_match_nxt = r_match + 1'b1;
                  end
               end else begin
                  w_match_nxt = '0;
               end
            end
            LOCKED: begin
               // Flywheel: the prediction, not the received bit, feeds history
               // so isolated errors do not corrupt later predictions.
               w_hist_nxt = {r_hist[LFSR_W-2:0], w_pred};
               if (in_bit != w_pred) begin
                  w_err = 1'b1;
                  if (r_miss == LW'(LOSS_CNT - 1)) begin
                     w_state_nxt = SEARCH;
                     w_fill_nxt  = '0;
                     w_miss_nxt  = '0;
                  end else begin
                     w_miss_nxt = r_miss + 1'b1;
                  end
               end else begin
                  w_miss_nxt = '0;
               end
            end
            default: w_state_nxt = SEARCH;
         endcase
      end
   end

   assign locked    = (r_state == LOCKED);
   assign err_pulse = r_err_pulse;

`ifdef LFSR_CHK_ERR_CNT_EN
   logic [ERR_W-1:0] w_err_cnt;

   lfsr_chk_sat_cnt #(.W(ERR_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst),
      .i_clr (clr_err),
      .i_inc (w_err),
      .o_cnt (w_err_cnt)
   );

   assign err_cnt = w_err_cnt;
`else
   logic w_unused_clr;
   assign w_unused_clr = clr_err;
   assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: table of stream scenarios with
// expected lock/pulse/count results, plus hand sequences for pulse width,
// clear/error collision and asynchronous reset. A second instance with
// ERR_W=2 runs on the same stimulus to cover saturation.
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        clr_err = 1'b0;
   logic        locked, err_pulse, locked2, err_pulse2;
   logic [15:0] err_cnt;
   logic [1:0]  err_cnt2;

   always #5 clk = ~clk;

   lfsr_checker #(.LOCK_CNT(8), .LOSS_CNT(3), .ERR_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .clr_err(clr_err), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
   );

   lfsr_checker #(.LOCK_CNT(8), .LOSS_CNT(3), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .clr_err(clr_err), .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2)
   );

   int total  = 0;
   int passed = 0;
   int ph     = 0;
   int pulses = 0;

   // Generator output from seed 1111, one period.
   bit ref_seq [15] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};

   typedef struct {
      string       name;
      bit          rst_first;
      bit          gap;
      bit          zero;
      bit          clr0;
      int          n;
      logic [39:0] inv;
      bit          exp_locked;
      int          exp_pulses;
      int          exp_err;
   } vec_t;

   vec_t vecs [13];
   vec_t sb [$];

   function automatic int ee(input int x);
`ifdef LFSR_CHK_ERR_CNT_EN
      return x;
`else
      return 0 * x;
`endif
   endfunction

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic beat(input bit v, input bit b, input bit c);
      in_valid = v;
      in_bit   = b;
      clr_err  = c;
      @(posedge clk);
      #1;
      if (err_pulse) pulses++;
      in_valid = 1'b0;
      in_bit   = 1'b0;
      clr_err  = 1'b0;
   endtask

   task automatic send(input bit inv, input bit c);
      bit b;
      b  = ref_seq[ph] ^ inv;
      ph = (ph + 1) % 15;
      beat(1'b1, b, c);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      clr_err  = 1'b0;
      rst      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      vec_t v, e;
      //            name           rst gap zero clr  n   inv          lk pul err
      vecs[0]  = '{"pre_lock11",    0,  0,  0,  0,  11, 40'h0,       0, 0, 0};
      vecs[1]  = '{"lock12",        0,  0,  0,  0,   1, 40'h0,       1, 0, 0};
      vecs[2]  = '{"clean20",       0,  0,  0,  0,  20, 40'h0,       1, 0, 0};
      vecs[3]  = '{"single_err",    0,  0,  0,  0,   5, 40'h4,       1, 1, 1};
      vecs[4]  = '{"clean_clr",     0,  0,  0,  1,  10, 40'h0,       1, 0, 0};
      vecs[5]  = '{"loss3",         0,  0,  0,  0,   3, 40'h7,       0, 3, 3};
      vecs[6]  = '{"reacq11",       0,  0,  0,  0,  11, 40'h0,       0, 0, 3};
      vecs[7]  = '{"reacq12",       0,  0,  0,  0,   1, 40'h0,       1, 0, 3};
      vecs[8]  = '{"gap11",         1,  1,  0,  0,  11, 40'h0,       0, 0, 0};
      vecs[9]  = '{"gap12",         0,  1,  0,  0,   1, 40'h0,       1, 0, 0};
      vecs[10] = '{"zeros40",       1,  0,  1,  0,  40, 40'h0,       0, 0, 0};
      vecs[11] = '{"relock",        1,  0,  0,  0,  12, 40'h0,       1, 0, 0};
      vecs[12] = '{"five_isolated", 0,  0,  0,  0,  20, 40'h11111,   1, 5, 5};

      do_reset();
      check("reset_locked", int'(locked), 0);
      check("reset_pulse",  int'(err_pulse), 0);
      check("reset_err",    int'(err_cnt), 0);

      for (int i = 0; i < 13; i++) begin
         v = vecs[i];
         if (i == 8) begin
            // Hand sequences while locked, continuing the stream of vector 7.
            pulses = 0;
            send(1'b1, 1'b0);
            check("h1_pulse_hi",  int'(err_pulse), 1);
            check("h1_err_same",  int'(err_cnt),  ee(4));
            check("h1_err2_sat",  int'(err_cnt2), ee(3));
            beat(1'b0, 1'b0, 1'b0);
            check("h1_pulse_lo",  int'(err_pulse), 0);
            check("h1_err_hold",  int'(err_cnt),  ee(4));
            send(1'b0, 1'b0);
            send(1'b1, 1'b1);
            check("h2_clr_err",   int'(err_cnt),  ee(1));
            check("h2_locked",    int'(locked),   1);
            send(1'b0, 1'b0);
            #2;
            rst = 1'b0;
            #1;
            check("h3_async_locked", int'(locked),   0);
            check("h3_async_err",    int'(err_cnt),  0);
            check("h3_async_err2",   int'(err_cnt2), 0);
            check("h3_async_pulse",  int'(err_pulse), 0);
            #2;
            rst = 1'b1;
         end
         sb.push_back(v);
         if (v.rst_first) do_reset();
         pulses = 0;
         for (int k = 0; k < v.n; k++) begin
            if (v.zero) beat(1'b1, 1'b0, v.clr0 && (k == 0));
            else        send(v.inv[k], v.clr0 && (k == 0));
            if (v.gap) beat(1'b0, 1'b0, 1'b0);
         end
         e = sb.pop_front();
         check({e.name, "_locked"}, int'(locked),   int'(e.exp_locked));
         check({e.name, "_pulses"}, pulses,         e.exp_pulses);
         check({e.name, "_err"},    int'(err_cnt),  ee(e.exp_err));
         check({e.name, "_err2"},   int'(err_cnt2), ee(sat3(e.exp_err)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
